// File: rtl/seq_div.sv
// Multi-cycle signed restoring divider: one trial subtraction per cycle on operand
// magnitudes, sign fix-up when the last quotient bit lands, start/done handshake.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// CALC  | N shift/trial-subtract iterations, counter counts N down to 1
// DONE  | one-cycle result pulse; q/r/dbz/ovf were registered on entry

module seq_div #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         dbz,
    output logic         ovf
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    // Dividend magnitude shifts out of the top while quotient bits shift in at the bottom.
    logic [N-1:0]   dvd_q, dvd_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic [N:0]     rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sgn_quo_q, sgn_quo_d;
    logic           sgn_rem_q, sgn_rem_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   r_q, r_d;
    logic           dbz_q, dbz_d;
    logic           ovf_q, ovf_d;

    logic [N-1:0]   a_mag, b_mag;
    logic [N:0]     rem_sh;
    logic           qbit;
    logic [N:0]     rem_nx;
    logic [N-1:0]   dvd_nx;

    always_comb begin
        a_mag  = a[N-1] ? -a : a;
        b_mag  = b[N-1] ? -b : b;
        rem_sh = {rem_q[N-1:0], dvd_q[N-1]};
        qbit   = (rem_sh >= {1'b0, dvs_q});
        rem_nx = qbit ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
        dvd_nx = {dvd_q[N-2:0], qbit};
    end

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        sgn_quo_d = sgn_quo_q;
        sgn_rem_d = sgn_rem_q;
        q_d       = q_q;
        r_d       = r_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sgn_quo_d = a[N-1] ^ b[N-1];
                    sgn_rem_d = a[N-1];
                    dvd_d     = a_mag;
                    dvs_d     = b_mag;
                    rem_d     = '0;
                    cnt_d     = CW'(N);
                    dbz_d     = 1'b0;
                    ovf_d     = 1'b0;
                    if (b == '0) begin
                        dbz_d   = 1'b1;
                        q_d     = '1;
                        r_d     = a;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                dvd_d = dvd_nx;
                rem_d = rem_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    q_d     = sgn_quo_q ? -dvd_nx : dvd_nx;
                    r_d     = sgn_rem_q ? -rem_nx[N-1:0] : rem_nx[N-1:0];
                    // A positive quotient reaching 2^(N-1) only arises from MIN / -1.
                    ovf_d   = ~sgn_quo_q & dvd_nx[N-1];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            sgn_quo_q <= sgn_quo_d;
            sgn_rem_q <= sgn_rem_d;
            q_q       <= q_d;
            r_q       <= r_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign q    = q_q;
    assign r    = r_q;
    assign dbz  = dbz_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: directed literal cases plus randomized operands checked every
// cycle against a truncating-division model with a cycle-accurate result schedule.

module tb_seq_div;
    localparam int N = 32;
    localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy, done, dbz, ovf;
    logic [N-1:0] q, r;

    seq_div #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .q    (q),
        .r    (r),
        .dbz  (dbz),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           acc;
        int           due;
        logic [N-1:0] av;
        logic [N-1:0] bv;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        logic         ovf;
    } exp_t;

    exp_t         expq[$];
    exp_t         cur;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           busy_until = -1;
    int           prev_done = -1;
    int           done_gap = 0;
    logic [N-1:0] last_q = '0;
    logic [N-1:0] last_r = '0;
    logic         last_dbz = 1'b0;
    logic         last_ovf = 1'b0;
    logic         exp_done, exp_busy;
    logic [N-1:0] recon;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain truncating signed division in 64-bit arithmetic.
    function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv, input int acc);
        exp_t   e;
        longint sa, sb, lq, lr;
        e.acc = acc;
        e.av  = av;
        e.bv  = bv;
        if (bv == '0) begin
            e.due = acc + 1;
            e.q   = '1;
            e.r   = av;
            e.dbz = 1'b1;
            e.ovf = 1'b0;
        end else begin
            sa    = longint'($signed(av));
            sb    = longint'($signed(bv));
            lq    = sa / sb;
            lr    = sa % sb;
            e.due = acc + N + 1;
            e.q   = lq[N-1:0];
            e.r   = lr[N-1:0];
            e.dbz = 1'b0;
            e.ovf = (av == MIN) && (bv == '1);
        end
        return e;
    endfunction

    function automatic logic [N-1:0] rand_op();
        logic [N-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = MIN;
            1:       v = '1;
            2:       v = {1'b0, {(N-1){1'b1}}};
            3:       v = N'($urandom_range(0, 40)) - N'(20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    function automatic logic [N-1:0] rand_nz();
        logic [N-1:0] v;
        v = rand_op();
        while (v == '0) v = rand_op();
        return v;
    endfunction

    // Called just after a falling edge: drives start for this cycle, records the
    // expected result if the divider is idle in this cycle, then advances one cycle.
    task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv, input bit lit,
                         input logic [N-1:0] lq, input logic [N-1:0] lr,
                         input logic ldbz, input logic lovf);
        exp_t e;
        start = 1'b1;
        a     = av;
        b     = bv;
        if (cyc > busy_until) begin
            e = model(av, bv, cyc);
            if (lit) begin
                e.q   = lq;
                e.r   = lr;
                e.dbz = ldbz;
                e.ovf = lovf;
            end
            expq.push_back(e);
            busy_until = e.due;
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        while (cyc <= busy_until) @(negedge clk);
    endtask

    task automatic op_lit(input logic [N-1:0] av, input logic [N-1:0] bv,
                          input logic [N-1:0] lq, input logic [N-1:0] lr,
                          input logic ldbz, input logic lovf);
        issue(av, bv, 1'b1, lq, lr, ldbz, lovf);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        wait_idle();
    endtask

    always @(negedge clk) begin
        exp_done = (expq.size() > 0) && (expq[0].due == cyc);
        exp_busy = (expq.size() > 0) && (cyc > expq[0].acc);
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        if (exp_done) begin
            cur = expq.pop_front();
            chk("q", q, cur.q);
            chk("r", r, cur.r);
            chk("dbz", dbz, cur.dbz);
            chk("ovf", ovf, cur.ovf);
            if (!cur.dbz) begin
                recon = q * cur.bv + r;
                chk("invariant", recon, cur.av);
            end
            last_q   = cur.q;
            last_r   = cur.r;
            last_dbz = cur.dbz;
            last_ovf = cur.ovf;
        end else if (!exp_busy) begin
            chk("hold_q", q, last_q);
            chk("hold_r", r, last_r);
            chk("hold_dbz", dbz, last_dbz);
            chk("hold_ovf", ovf, last_ovf);
        end
        if (done === 1'b1) begin
            if (prev_done >= 0) done_gap = cyc - prev_done;
            prev_done = cyc;
        end
    end

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_q", q, '0);
        chk("reset_r", r, '0);
        @(negedge clk);

        op_lit(32'd7,          32'd2,          32'd3,          32'd1,          1'b0, 1'b0);
        op_lit(32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0);
        op_lit(32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 1'b0);
        op_lit(32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 1'b0);
        op_lit(32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1);
        op_lit(32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0, 1'b0);
        op_lit(32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1'b0);

        // Second start with new operands mid-operation must be dropped.
        issue(32'd1000, 32'd3, 1'b1, 32'd333, 32'd1, 1'b0, 1'b0);
        start = 1'b0;
        repeat (4) @(negedge clk);
        issue(32'd50, 32'd5, 1'b0, '0, '0, 1'b0, 1'b0);
        start = 1'b0;
        wait_idle();

        // Start held high: re-triggers in every idle cycle.
        for (int i = 0; i < 3 * (N + 2); i++) issue(rand_op(), rand_nz(), 1'b0, '0, '0, 1'b0, 1'b0);
        start = 1'b0;
        wait_idle();
        chk("b2b_gap", done_gap, N + 2);

        // Asynchronous reset between clock edges in the middle of CALC.
        issue(32'd123456, 32'd7, 1'b0, '0, '0, 1'b0, 1'b0);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_q", q, '0);
        chk("arst_r", r, '0);
        chk("arst_dbz", dbz, 1'b0);
        chk("arst_ovf", ovf, 1'b0);
        expq.delete();
        busy_until = -1;
        last_q   = '0;
        last_r   = '0;
        last_dbz = 1'b0;
        last_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        op_lit(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            issue(rand_op(), rand_nz(), 1'b0, '0, '0, 1'b0, 1'b0);
            start = 1'b0;
            a     = $urandom;
            b     = $urandom;
            wait_idle();
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
